// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
// Optional feature: ADDER_ARB_RR_EN selects round-robin arbitration (see adder_arb_grant).
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 32;

    // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_arb_grant.sv
// Combinational grant-index selection among asserted request bits.
// ADDER_ARB_RR_EN defined: round-robin starting after ptr; undefined: lowest index wins.
module adder_arb_grant #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
`ifdef ADDER_ARB_RR_EN
    input  logic [ID_W-1:0]    ptr,
`endif
    output logic               grant_any,
    output logic [ID_W-1:0]    grant_idx
);

`ifdef ADDER_ARB_RR_EN
    // First pass covers indices above the pointer, second pass wraps to 0..ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req_valid[i] && (i > int'(ptr))) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req_valid[i] && (i <= int'(ptr))) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end
`else
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/adder_share_arbiter.sv
// Time-shares one external combinational adder among NUM_REQ requesters, one add in flight.
// Optional feature: ADDER_ARB_RR_EN enables round-robin grant with a pointer register.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_cin,
    output logic [DATA_W-1:0]         add_a,
    output logic [DATA_W-1:0]         add_b,
    output logic                      add_cin,
    input  logic [DATA_W-1:0]         add_s,
    input  logic                      add_cout,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic                      rsp_cout,
    output logic                      rsp_ovf
);

    arb_state_t        state_q, state_d;
    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic              sel_cin;

`ifdef ADDER_ARB_RR_EN
    logic [ID_W-1:0]   ptr_q;
`endif

    adder_arb_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_grant (
        .req_valid (req_valid),
`ifdef ADDER_ARB_RR_EN
        .ptr       (ptr_q),
`endif
        .grant_any (grant_any),
        .grant_idx (grant_idx)
    );

    assign rsp_valid = (state_q == RESP);

    // Grant only the asserted winner; the handshake is therefore implied by grant_any in IDLE.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        sel_a     = '0;
        sel_b     = '0;
        sel_cin   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a   = req_a[i*DATA_W +: DATA_W];
                sel_b   = req_b[i*DATA_W +: DATA_W];
                sel_cin = req_cin[i];
            end
        end
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        req_ready[i] = (grant_idx == ID_W'(i));
                    end
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            add_a    <= '0;
            add_b    <= '0;
            add_cin  <= 1'b0;
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_ovf  <= 1'b0;
`ifdef ADDER_ARB_RR_EN
            ptr_q    <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                add_a   <= sel_a;
                add_b   <= sel_b;
                add_cin <= sel_cin;
                rsp_id  <= grant_idx;
`ifdef ADDER_ARB_RR_EN
                ptr_q   <= grant_idx;
`endif
            end
            // Operands have been stable for a full cycle, so the adder output is settled here.
            if (state_q == EXEC) begin
                rsp_sum  <= add_s;
                rsp_cout <= add_cout;
                rsp_ovf  <= signed_ovf(add_a[DATA_W-1], add_b[DATA_W-1], add_s[DATA_W-1]);
            end
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter with a behavioural model of the shared adder.
// Expected grant order follows ADDER_ARB_RR_EN when it is defined.
module tb_adder_share_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  req_valid = '0;
    logic [NR-1:0]  req_ready;
    logic [NR*DW-1:0] req_a = '0;
    logic [NR*DW-1:0] req_b = '0;
    logic [NR-1:0]  req_cin = '0;
    logic [DW-1:0]  add_a, add_b, add_s;
    logic           add_cin, add_cout;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [IW-1:0]  rsp_id;
    logic [DW-1:0]  rsp_sum;
    logic           rsp_cout, rsp_ovf;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] sum;
        logic          cout;
        logic          ovf;
    } rsp_t;

    rsp_t sb[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   cyc          = 0;
    int   accept_cyc   = 0;
    logic prev_valid   = 1'b0;

    // The shared adder lives outside the arbiter; model it here.
    logic [DW:0] add_full;
    assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};
    assign add_s    = add_full[DW-1:0];
    assign add_cout = add_full[DW];

    adder_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pops an expectation on every response handshake; also tracks grant exclusivity and latency.
    task automatic monitorLoop();
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                checkOutput("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
                if (|(req_valid & req_ready)) accept_cyc = cyc;
                if (rsp_valid && !prev_valid) checkOutput("latency", 64'(cyc - accept_cyc), 64'd2);
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        n_compared++;
                        n_mismatched++;
                        $display("[TB] FAIL unexpected_rsp: got id %0d sum %0h, want no response", rsp_id, rsp_sum);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("rsp{id,sum,cout,ovf}", 64'({rsp_id, rsp_sum, rsp_cout, rsp_ovf}), 64'(e));
                    end
                end
                prev_valid = rsp_valid;
            end
        end
    endtask

    task automatic raiseReq(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin);
        req_a[id*DW +: DW] = a;
        req_b[id*DW +: DW] = b;
        req_cin[id]        = cin;
        req_valid[id]      = 1'b1;
    endtask

    // Waits for requester id to be accepted, then drops its valid just after the accepting edge.
    task automatic waitAccept(input int id, output int acc);
        bit got = 1'b0;
        acc = -1;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (req_valid[id] && req_ready[id]) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        if (!got) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL accept_timeout: requester %0d got no grant, want grant within 60 cycles", id);
        end
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic applyStimulus(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin,
                                 input logic [DW-1:0] s, input logic co, input logic ov);
        int acc;
        sb.push_back('{id: IW'(id), sum: s, cout: co, ovf: ov});
        raiseReq(id, a, b, cin);
        waitAccept(id, acc);
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || rsp_valid) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL drain_timeout: %0d responses still pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        checkOutput({tag, "_add_a"}, 64'(add_a), 64'd0);
        checkOutput({tag, "_add_b"}, 64'(add_b), 64'd0);
        checkOutput({tag, "_add_cin"}, 64'(add_cin), 64'd0);
        checkOutput({tag, "_rsp_fields"}, 64'({rsp_id, rsp_sum, rsp_cout, rsp_ovf}), 64'd0);
    endtask

    initial begin
        int acc_c[5];
        int nacc;
        int acc, h;
        logic [IW-1:0] exp_ids[5];
        logic [DW-1:0] exp_sums[4];

        fork
            monitorLoop();
            begin
                #200000;
                $display("[TB] FAIL watchdog: simulation still running, want completion");
                $fatal(1, "[TB] watchdog expired");
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkAllZero("reset");

        // Contention: all four held valid, operands a=0x10*(i+1), b=i
        exp_sums[0] = 32'h10; exp_sums[1] = 32'h21; exp_sums[2] = 32'h32; exp_sums[3] = 32'h43;
`ifdef ADDER_ARB_RR_EN
        exp_ids[0] = 2'd0; exp_ids[1] = 2'd1; exp_ids[2] = 2'd2; exp_ids[3] = 2'd3; exp_ids[4] = 2'd0;
`else
        exp_ids[0] = 2'd0; exp_ids[1] = 2'd0; exp_ids[2] = 2'd0; exp_ids[3] = 2'd0; exp_ids[4] = 2'd0;
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++)
            sb.push_back('{id: exp_ids[i], sum: exp_sums[exp_ids[i]], cout: 1'b0, ovf: 1'b0});
        for (int i = 0; i < NR; i++) raiseReq(i, DW'(32'h10 * (i + 1)), DW'(i), 1'b0);
        nacc = 0;
        for (int k = 0; k < 100 && nacc < 5; k++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                acc_c[nacc] = cyc;
                nacc++;
            end
        end
        @(posedge clk);
        #1 req_valid = '0;
        checkOutput("contention_accepts", 64'(nacc), 64'd5);
        for (int i = 1; i < 5; i++) checkOutput("contention_spacing", 64'(acc_c[i] - acc_c[i-1]), 64'd3);
        drain();

        // Single add
        @(posedge clk);
        #1 applyStimulus(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
        drain();

        // Backpressure with overflow response; req2 (carry case) waits behind it
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        applyStimulus(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        sb.push_back('{id: 2'd2, sum: 32'h0, cout: 1'b1, ovf: 1'b0});
        raiseReq(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
        checkOutput("bp_valid", 64'(rsp_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_hold", 64'({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf}),
                        64'({1'b1, 2'd1, 32'h8000_0000, 1'b0, 1'b1}));
            checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        h = cyc;
        waitAccept(2, acc);
        checkOutput("bp_next_accept", 64'(acc), 64'(h + 1));
        drain();

        // Reset during EXEC discards the in-flight add
        @(posedge clk);
        #1 raiseReq(2, 32'h1, 32'h1, 1'b0);
        waitAccept(2, acc);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkAllZero("midrst");

        // After reset index 0 wins over 3; then req3 exercises carry-in
        @(posedge clk);
        #1;
        sb.push_back('{id: 2'd0, sum: 32'h123, cout: 1'b0, ovf: 1'b0});
        sb.push_back('{id: 2'd3, sum: 32'h1, cout: 1'b0, ovf: 1'b0});
        raiseReq(0, 32'h100, 32'h23, 1'b0);
        raiseReq(3, 32'h0, 32'h0, 1'b1);
        waitAccept(0, acc);
        waitAccept(3, acc);
        drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
